button_event_encoder: RTL and testbench

Front-end conditioner for the traffic-light controller's six push buttons: changeMode, config, changeLight, increaseTime, decreaseTime and confirm. Each button is synchronised and debounced, and each press becomes a single-cycle pulse. Presses are also encoded into a one-entry event register with a valid/ack handshake, which the mode/config FSM in main consumes. The block sits between the board pins and main's control logic.

---
 rtl/button_event_if.sv | 23 ++
 rtl/button_event_encoder.sv | 144 ++++++++++++++
 tb/tb_button_event_encoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Button/event bundle between the board-side button pins and main's mode/config FSM.
// slave = encoder side, master = consumer/stimulus side.
interface button_event_if;
    logic [5:0] btn_raw;
    logic [5:0] btn_level;
    logic [5:0] btn_pulse;
    logic       event_valid;
    logic [2:0] event_code;
    logic       event_repeat;
    logic       event_ack;
    logic       event_overflow;
    logic       ovf_clear;

    modport slave (
        input  btn_raw, event_ack, ovf_clear,
        output btn_level, btn_pulse, event_valid, event_code, event_repeat, event_overflow
    );

    modport master (
        output btn_raw, event_ack, ovf_clear,
        input  btn_level, btn_pulse, event_valid, event_code, event_repeat, event_overflow
    );
endinterface

// File: rtl/button_event_encoder.sv
// Six-button synchroniser/debouncer with press pulses and a one-entry event register.
// Define AUTO_REPEAT_EN to add hold-to-repeat on increaseTime (bit 3) and decreaseTime (bit 4).
module button_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10
) (
    input  logic               clk,
    input  logic               reset,
    button_event_if.slave      bus
);
    localparam int NB    = 6;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NB-1:0]    sync1, sync2, level, pulse, pulse_rpt;
    logic [NB-1:0]    lvl_next, rise, fire, win_mask;
    logic [CNT_W-1:0] cnt      [NB];
    logic [CNT_W-1:0] cnt_next [NB];
    logic             ev_valid, ev_rpt, ovf;
    logic [2:0]       ev_code, win_code;
    logic             win_rpt, accept, drop;

    // Level toggles one cycle after the counter has seen DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cnt_next[i] = cnt[i];
            lvl_next[i] = level[i];
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    lvl_next[i] = ~level[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end else begin
                cnt_next[i] = '0;
            end
        end
        rise = lvl_next & ~level;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rtmr      [2];
    logic [RPT_W-1:0] rtmr_next [2];
    logic [1:0]       rfire;

    // Down-counter per repeating button; terminal count fires a pulse and reloads the rate.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            rfire[j]     = 1'b0;
            rtmr_next[j] = rtmr[j];
            if (!lvl_next[3+j]) begin
                rtmr_next[j] = '0;
            end else if (rise[3+j]) begin
                rtmr_next[j] = RPT_W'(REPEAT_DELAY - 1);
            end else if (rtmr[j] == '0) begin
                rfire[j]     = 1'b1;
                rtmr_next[j] = RPT_W'(REPEAT_RATE - 1);
            end else begin
                rtmr_next[j] = rtmr[j] - 1'b1;
            end
        end
        fire = {1'b0, rfire, 3'b000};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtmr[0] <= '0;
            rtmr[1] <= '0;
        end else begin
            rtmr[0] <= rtmr_next[0];
            rtmr[1] <= rtmr_next[1];
        end
    end
`else
    assign fire = '0;
`endif

    // Lowest set pulse index wins the event register.
    always_comb begin
        win_code = '0;
        win_rpt  = 1'b0;
        win_mask = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                win_code    = 3'(i + 1);
                win_rpt     = pulse_rpt[i];
                win_mask    = '0;
                win_mask[i] = 1'b1;
            end
        end
        accept = (pulse != '0) && (!ev_valid || bus.event_ack);
        drop   = accept ? |(pulse & ~win_mask) : |pulse;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            level     <= '0;
            pulse     <= '0;
            pulse_rpt <= '0;
            cnt       <= '{default: '0};
            ev_valid  <= 1'b0;
            ev_code   <= '0;
            ev_rpt    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            sync1     <= bus.btn_raw;
            sync2     <= sync1;
            level     <= lvl_next;
            cnt       <= cnt_next;
            pulse     <= rise | fire;
            pulse_rpt <= fire;

            if (accept) begin
                ev_valid <= 1'b1;
                ev_code  <= win_code;
                ev_rpt   <= win_rpt;
            end else if (ev_valid && bus.event_ack) begin
                ev_valid <= 1'b0;
                ev_code  <= '0;
                ev_rpt   <= 1'b0;
            end

            // A drop in the same cycle as ovf_clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clear) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.btn_level      = level;
    assign bus.btn_pulse      = pulse;
    assign bus.event_valid    = ev_valid;
    assign bus.event_code     = ev_code;
    assign bus.event_repeat   = ev_rpt;
    assign bus.event_overflow = ovf;
endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder; checks debounce latency, glitch rejection,
// event priority/overflow, handshake and (with AUTO_REPEAT_EN) repeat timing.
module tb_button_event_encoder;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    button_event_if bus ();

    button_event_encoder #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the cycle where btn_pulse[idx] is high, or reports a timeout.
    task automatic wait_pulse(input int idx);
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (bus.btn_pulse[idx]) seen = 1'b1;
        end
        if (!seen) check($sformatf("pulse%0d_timeout", idx), 32'(seen), 32'd1);
    endtask

    initial begin
        bit exp_p, exp_v;

        reset         = 1'b0;
        bus.btn_raw   = 6'h3F;
        bus.event_ack = 1'b0;
        bus.ovf_clear = 1'b0;
        tick(4);
        check("rst_level", 32'(bus.btn_level), 32'h0);
        check("rst_pulse", 32'(bus.btn_pulse), 32'h0);
        check("rst_valid", 32'(bus.event_valid), 32'h0);
        check("rst_code", 32'(bus.event_code), 32'h0);
        check("rst_repeat", 32'(bus.event_repeat), 32'h0);
        check("rst_ovf", 32'(bus.event_overflow), 32'h0);

        // Press latency: level rises after edge 6, pulse for one cycle, event next edge.
        reset       = 1'b1;
        bus.btn_raw = 6'h00;
        tick(3);
        bus.btn_raw = 6'h04;
        tick(6);
        check("lat_level_e5", 32'(bus.btn_level), 32'h0);
        tick();
        check("lat_level_e6", 32'(bus.btn_level), 32'h04);
        check("lat_pulse_e6", 32'(bus.btn_pulse), 32'h04);
        check("lat_valid_e6", 32'(bus.event_valid), 32'h0);
        tick();
        check("lat_pulse_e7", 32'(bus.btn_pulse), 32'h0);
        check("lat_valid_e7", 32'(bus.event_valid), 32'h1);
        check("lat_code_e7", 32'(bus.event_code), 32'd3);
        bus.event_ack = 1'b1;
        tick();
        bus.event_ack = 1'b0;
        check("ack_valid", 32'(bus.event_valid), 32'h0);
        check("ack_code", 32'(bus.event_code), 32'h0);

        // Glitch rejection on bit 5 while bit 2 stays held.
        bus.btn_raw = 6'h24;
        tick(3);
        bus.btn_raw = 6'h04;
        tick(10);
        check("glitch3_level", 32'(bus.btn_level), 32'h04);
        check("glitch3_valid", 32'(bus.event_valid), 32'h0);
        bus.btn_raw = 6'h24;
        #2;
        bus.btn_raw = 6'h04;
        tick(10);
        check("glitch2ns_level", 32'(bus.btn_level), 32'h04);
        check("glitch2ns_valid", 32'(bus.event_valid), 32'h0);
        bus.btn_raw = 6'h24;
        wait_pulse(5);
        tick();
        check("hold5_valid", 32'(bus.event_valid), 32'h1);
        check("hold5_code", 32'(bus.event_code), 32'd6);
        check("hold5_ovf", 32'(bus.event_overflow), 32'h0);
        bus.event_ack = 1'b1;
        tick();
        bus.event_ack = 1'b0;
        bus.btn_raw   = 6'h00;
        tick(12);
        check("release_level", 32'(bus.btn_level), 32'h0);
        check("release_valid", 32'(bus.event_valid), 32'h0);

        // Simultaneous bits 0 and 3: bit 0 wins, bit 3 dropped.
        bus.btn_raw = 6'h09;
        wait_pulse(0);
        check("prio_pulse", 32'(bus.btn_pulse), 32'h09);
        tick();
        check("prio_code", 32'(bus.event_code), 32'd1);
        check("prio_ovf", 32'(bus.event_overflow), 32'h1);
        check("prio_repeat", 32'(bus.event_repeat), 32'h0);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        check("ovf_clear", 32'(bus.event_overflow), 32'h0);
        check("ovf_clear_code", 32'(bus.event_code), 32'd1);
        bus.event_ack = 1'b1;
        bus.btn_raw   = 6'h00;
        tick();
        bus.event_ack = 1'b0;
        tick(12);

        // Pending event blocks a new press, then ack + pulse reloads with no bubble.
        bus.btn_raw = 6'h02;
        wait_pulse(1);
        tick();
        check("pend_code", 32'(bus.event_code), 32'd2);
        bus.btn_raw = 6'h10;
        wait_pulse(4);
        tick();
        check("pend_drop_ovf", 32'(bus.event_overflow), 32'h1);
        check("pend_drop_code", 32'(bus.event_code), 32'd2);
        check("pend_drop_valid", 32'(bus.event_valid), 32'h1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        bus.btn_raw   = 6'h02;
        wait_pulse(1);
        bus.event_ack = 1'b1;
        tick();
        bus.event_ack = 1'b0;
        check("b2b_valid", 32'(bus.event_valid), 32'h1);
        check("b2b_code", 32'(bus.event_code), 32'd2);
        check("b2b_ovf", 32'(bus.event_overflow), 32'h0);
        bus.event_ack = 1'b1;
        tick();
        bus.event_ack = 1'b0;
        check("b2b_ack_valid", 32'(bus.event_valid), 32'h0);
        bus.btn_raw = 6'h00;
        tick(12);

        // Hold bit 3; press pulse at offset 0, raw released after offset 40,
        // level falls at offset 47 so the last repeat is at 45.
        bus.btn_raw = 6'h08;
        wait_pulse(3);
        for (int off = 1; off <= 60; off++) begin
            tick();
            bus.event_ack = 1'b0;
`ifdef AUTO_REPEAT_EN
            exp_p = (off >= 20) && (off <= 45) && ((off - 20) % 5 == 0);
            exp_v = (off == 1) || ((off >= 21) && (off <= 46) && ((off - 21) % 5 == 0));
`else
            exp_p = 1'b0;
            exp_v = (off == 1);
`endif
            check($sformatf("rpt_pulse_%0d", off), 32'(bus.btn_pulse[3]), 32'(exp_p));
            check($sformatf("rpt_valid_%0d", off), 32'(bus.event_valid), 32'(exp_v));
            if (exp_v) begin
                check($sformatf("rpt_code_%0d", off), 32'(bus.event_code), 32'd4);
                check($sformatf("rpt_flag_%0d", off), 32'(bus.event_repeat), 32'(off != 1));
                bus.event_ack = 1'b1;
            end
            if (off == 46) check("rpt_level_46", 32'(bus.btn_level[3]), 32'h1);
            if (off == 47) check("rpt_level_47", 32'(bus.btn_level[3]), 32'h0);
            if (off == 40) bus.btn_raw = 6'h00;
        end
        bus.event_ack = 1'b0;
        check("rpt_ovf", 32'(bus.event_overflow), 32'h0);

        // Reset mid-hold discards level and the pending event.
        bus.btn_raw = 6'h08;
        wait_pulse(3);
        tick(3);
        check("midrst_pre_valid", 32'(bus.event_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_level", 32'(bus.btn_level), 32'h0);
        check("midrst_valid", 32'(bus.event_valid), 32'h0);
        check("midrst_code", 32'(bus.event_code), 32'h0);
        check("midrst_pulse", 32'(bus.btn_pulse), 32'h0);
        tick();
        reset = 1'b1;
        wait_pulse(3);
        check("midrst_repress_level", 32'(bus.btn_level), 32'h08);
        bus.btn_raw = 6'h00;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
